seven_segment_scanner: RTL and testbench

//   Downstream consumer of the decade counter chain. Takes NUM_DIGITS packed BCD digits and

---
 rtl/display_pkg.sv | 24 ++
 rtl/bcd_to_seven_segment.sv | 26 ++
 rtl/seven_segment_scanner.sv | 159 +++++++++++++++
 tb/tb_seven_segment_scanner.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and segment patterns for the multiplexed 7-segment scanner.
// Patterns are active-high {g,f,e,d,c,b,a}; polarity is applied at the pins.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GUARD,
    DRIVE
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seven_segment.sv
// Combinational BCD to 7-segment decoder, active-high gfedcba.
// Codes 10-15 show a lone dash so bad counter values are visible.
module bcd_to_seven_segment (
  input  logic [3:0] bcd_input,
  output logic [6:0] segment_output
);
  import display_pkg::*;

  always_comb begin
    segment_output = SEG_DASH;
    case (bcd_input)
      4'd0: segment_output = SEG_0;
      4'd1: segment_output = SEG_1;
      4'd2: segment_output = SEG_2;
      4'd3: segment_output = SEG_3;
      4'd4: segment_output = SEG_4;
      4'd5: segment_output = SEG_5;
      4'd6: segment_output = SEG_6;
      4'd7: segment_output = SEG_7;
      4'd8: segment_output = SEG_8;
      4'd9: segment_output = SEG_9;
      default: segment_output = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed 7-segment driver with per-frame snapshot,
// leading-zero blanking, anti-ghost guard slot and frame-done pulse.
module seven_segment_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIVIDER = 50000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                      control_clock,
  input  logic                      control_display_reset,
  input  logic                      control_display_enable,
  input  logic                      control_blank_leading_zeros,
  input  logic [4*NUM_DIGITS-1:0]   digits_input,
  input  logic [NUM_DIGITS-1:0]     dp_input,
  output logic [6:0]                segment_output,
  output logic                      dp_output,
  output logic [NUM_DIGITS-1:0]     anode_output,
  output logic                      control_frame_done
);
  import display_pkg::*;

  localparam int PW = (SCAN_DIVIDER > 1) ? $clog2(SCAN_DIVIDER) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIVIDER - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ACTIVE_LOW}};

  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

  digits_t                 digits_w;
  state_t                  state_q, state_d;
  logic [PW-1:0]           pre_q, pre_d;
  logic [IW-1:0]           idx_q, idx_d;
  digits_t                 shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   sdp_q, sdp_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    done_q, done_d;

  logic [NUM_DIGITS-1:0]   blank;
  logic                    nz_above;
  logic [3:0]              cur_digit;
  logic [6:0]              dec_seg;
  logic [6:0]              seg_act;
  logic                    dp_act;
  logic [NUM_DIGITS-1:0]   an_act;

  assign digits_w = digits_input;

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    sdp_d    = sdp_q;
    done_d   = 1'b0;
    if (!control_display_enable) begin
      state_d = IDLE;
      pre_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = GUARD;
          pre_d    = '0;
          idx_d    = '0;
          shadow_d = digits_w;
          sdp_d    = dp_input;
        end
        GUARD: begin
          state_d = DRIVE;
          pre_d   = pre_q + 1'b1;
        end
        DRIVE: begin
          if (pre_q == PRE_LAST) begin
            state_d = GUARD;
            pre_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d    = '0;
              shadow_d = digits_w;
              sdp_d    = dp_input;
              done_d   = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Scan from the MSD down; a digit blanks until a nonzero one is seen.
  always_comb begin
    blank    = '0;
    nz_above = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nz_above = nz_above | (shadow_d[k] != 4'd0);
      blank[k] = control_blank_leading_zeros & ~nz_above & (k != 0);
    end
  end

  assign cur_digit = shadow_d[idx_d];

  bcd_to_seven_segment u_dec (
    .bcd_input      (cur_digit),
    .segment_output (dec_seg)
  );

  // Pins decode the upcoming state so they move on the same edge as it.
  always_comb begin
    seg_act = SEG_BLANK;
    dp_act  = 1'b0;
    an_act  = '0;
    if (state_d != IDLE && !blank[idx_d]) begin
      seg_act = dec_seg;
      dp_act  = sdp_d[idx_d];
    end
    if (state_d == DRIVE) begin
      an_act = NUM_DIGITS'(1) << idx_d;
    end
    seg_d = seg_act ^ SEG_OFF;
    dp_d  = dp_act ^ ACTIVE_LOW;
    an_d  = an_act ^ AN_OFF;
  end

  always_ff @(posedge control_clock or posedge control_display_reset) begin
    if (control_display_reset) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      sdp_q    <= '0;
      seg_q    <= SEG_OFF;
      dp_q     <= ACTIVE_LOW;
      an_q     <= AN_OFF;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
      done_q   <= done_d;
    end
  end

  assign segment_output     = seg_q;
  assign dp_output          = dp_q;
  assign anode_output       = an_q;
  assign control_frame_done = done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: cycle-count display model plus
// hand-computed frame checks.
module tb_seven_segment_scanner;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int FL = N * SD;
  localparam bit AL = 1'b1;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        en   = 1'b0;
  logic        blen = 1'b0;
  logic [15:0] dig  = 16'h0;
  logic [3:0]  dpi  = 4'h0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        done;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .NUM_DIGITS   (N),
    .SCAN_DIVIDER (SD),
    .ACTIVE_LOW   (AL)
  ) dut (
    .control_clock               (clk),
    .control_display_reset       (rst),
    .control_display_enable      (en),
    .control_blank_leading_zeros (blen),
    .digits_input                (dig),
    .dp_input                    (dpi),
    .segment_output              (seg),
    .dp_output                   (dp),
    .anode_output                (an),
    .control_frame_done          (done)
  );

  int compared   = 0;
  int mismatched = 0;
  int done_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT at the last rising edge.
  logic        rst_s = 1'b0, en_s = 1'b0, blen_s = 1'b0;
  logic [15:0] dig_s = 16'h0;
  logic [3:0]  dp_s  = 4'h0;
  always @(posedge clk) begin
    rst_s  <= rst;
    en_s   <= en;
    blen_s <= blen;
    dig_s  <= dig;
    dp_s   <= dpi;
  end

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                               7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h40,
                               7'h40, 7'h40, 7'h40, 7'h40};

  // Model: n counts cycles since the display started; slot/phase derive from it.
  initial begin
    bit          m_act;
    int          m_n;
    logic [15:0] m_snap;
    logic [3:0]  m_dp;
    bit          m_done;
    int          slot, phase;
    logic [15:0] upper;
    logic [3:0]  dg;
    bit          blk;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    m_act = 0; m_n = 0; m_snap = 0; m_dp = 0; m_done = 0;
    forever begin
      @(negedge clk);
      if (rst || rst_s) begin
        m_act = 0; m_n = 0; m_snap = 0; m_dp = 0; m_done = 0;
      end else if (!en_s) begin
        m_act = 0; m_n = 0; m_done = 0;
      end else if (!m_act) begin
        m_act = 1; m_n = 0; m_snap = dig_s; m_dp = dp_s; m_done = 0;
      end else begin
        m_n++;
        m_done = 0;
        if (m_n == FL) begin
          m_n = 0; m_snap = dig_s; m_dp = dp_s; m_done = 1;
        end
      end
      slot  = m_n / SD;
      phase = m_n % SD;
      upper = m_snap >> (4 * slot);
      dg    = upper[3:0];
      blk   = blen_s && (slot != 0) && (upper == 16'h0);
      e_seg = (!m_act || blk) ? 7'h00 : seg_tab[dg];
      e_dp  = m_act && !blk && m_dp[slot];
      e_an  = (m_act && phase != 0) ? (4'b0001 << slot) : 4'b0000;
      chk("model_seg",  seg,  e_seg ^ {7{AL}});
      chk("model_dp",   dp,   e_dp ^ AL);
      chk("model_an",   an,   e_an ^ {4{AL}});
      chk("model_done", done, m_done);
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  // Starts with pins at the guard of digit 0; ends at the next one.
  task automatic frame_check(input logic [27:0] segs, input logic [3:0] dps);
    logic [15:0] an_tab;
    an_tab = 16'h7BDE;
    for (int s = 0; s < N; s++) begin
      chk("guard_seg", seg, segs[7*s +: 7]);
      chk("guard_an",  an,  4'hF);
      step(1);
      chk("drive_seg", seg, segs[7*s +: 7]);
      chk("drive_an",  an,  an_tab[4*s +: 4]);
      chk("drive_dp",  dp,  dps[s]);
      step(SD - 1);
    end
  endtask

  initial begin
    int dc0;
    step(1);
    chk("reset_an",   an,   4'hF);
    chk("reset_seg",  seg,  7'h7F);
    chk("reset_dp",   dp,   1'b1);
    chk("reset_done", done, 1'b0);
    rst = 1'b0;
    step(2);
    chk("idle_an", an, 4'hF);

    dig = 16'h1234; en = 1'b1;
    step(1);
    frame_check({7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);
    chk("wrap_done", done, 1'b1);

    step(1);
    #1 rst = 1'b1;
    #1;
    chk("rst_drive_an",   an,   4'hF);
    chk("rst_drive_seg",  seg,  7'h7F);
    chk("rst_drive_dp",   dp,   1'b1);
    chk("rst_drive_done", done, 1'b0);
    dig = 16'h0070; blen = 1'b1; dpi = 4'hF;
    step(1);
    rst = 1'b0;
    step(1);
    frame_check({7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b1100);

    blen = 1'b0; dpi = 4'h0; dig = 16'h1234;
    step(FL);
    step(5);
    dig = 16'h5678;
    step(3);
    chk("midframe_seg", seg, 7'h24);
    step(8);
    dc0 = done_cnt;
    frame_check({7'h12, 7'h02, 7'h78, 7'h00}, 4'hF);
    chk("done_once", done_cnt - dc0, 1);

    dig = 16'h567A;
    step(FL);
    chk("dash_guard_seg", seg, 7'h3F);
    step(1);
    chk("dash_drive_seg", seg, 7'h3F);
    chk("dash_drive_an",  an,  4'hE);

    step(5);
    en = 1'b0;
    dc0 = done_cnt;
    step(1);
    chk("off_an",   an,   4'hF);
    chk("off_seg",  seg,  7'h7F);
    chk("off_dp",   dp,   1'b1);
    chk("off_done", done, 1'b0);
    step(FL + 4);
    chk("off_no_done", done_cnt - dc0, 0);

    dig = 16'h9999; en = 1'b1;
    step(1);
    chk("reen_guard_seg", seg, 7'h10);
    chk("reen_guard_an",  an,  4'hF);
    step(1);
    chk("reen_drive_seg", seg, 7'h10);
    chk("reen_drive_an",  an,  4'hE);
    step(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
